ddr_main_sequencer: RTL and testbench
=====================================

# ddr_main_sequencer

Parametrised top-level sequencer for the DDR3 controller core. It brings the PHY and DRAM out of reset and runs per-rank ZQ long calibration. It then hands the command bus to the scheduler and periodically reclaims it for precharge-all plus auto-refresh, with postponed-refresh accounting. It sits between the DFI master and the DDR init engine on one side and the transaction scheduler on the other, and drives a registered DRAM command slot that the DFI mux forwards.

## Interface
- NUM_RANKS, 1: ranks (chip selects) served; 1..4.
- CNT_W, 16: width of all timing counters; every timing parameter must be < 2^CNT_W.
- T_ZQINIT, 512: cycles from ZQCL issue to the next command, per rank.
- T_RP, 6: cycles from PREA to REF.
- T_RFC, 88: cycles from REF to the next command.
- T_REFI, 6240: refresh interval in cycles.
- MAX_POSTPONE, 8: maximum outstanding refreshes; 1..8.
- core_clk  in  1  clock.
- core_arstn  in  1  reset, asynchronous, active-low.
- dfi_init_start  out  1  request PHY initialisation.
- dfi_init_complete  in  1  PHY initialisation done, level.
- ddr_init_start  out  1  start the DRAM init engine (MRS sequence).
- ddr_init_done  in  1  DRAM init engine done, level.
- sched_en  out  1  scheduler may issue commands.
- sched_idle  in  1  scheduler has no command in flight and all banks may be precharged.
- ref_urgent  out  1  ref_pending == MAX_POSTPONE.
- ref_overflow  out  1  sticky: an interval elapsed while saturated.
- cmd_valid  out  1  command slot valid this cycle.
- cmd_cs_n  out  NUM_RANKS  per-rank chip select, active-low.
- cmd_ras_n, cmd_cas_n, cmd_we_n  out  1 each  command code.
- cmd_a10  out  1  address bit 10 (all-banks / long).

## Operation
- States: RESET, INIT_DFI, INIT_DDR, ZQCAL, ZQWAIT, IDLE, PREA, PREA_WAIT, REF, REF_WAIT.
- RESET -> INIT_DFI unconditionally on the first clock after reset release.
- INIT_DFI: dfi_init_start=1. On dfi_init_complete=1, go to INIT_DDR; dfi_init_start drops on the same edge.
- INIT_DDR: ddr_init_start=1. On ddr_init_done=1, go to ZQCAL with rank index r=0.
- ZQCAL (1 cycle): issue ZQCL with cs_n[r]=0, others 1, ras/cas/we=1,1,0, a10=1. Go to ZQWAIT and load the counter with T_ZQINIT-1.
- ZQWAIT: when the counter reaches 0, go to ZQCAL with r+1 if r < NUM_RANKS-1; otherwise go to IDLE.
- IDLE: sched_en=1 while ref_pending==0.
  - When ref_pending>0, sched_en=0.
  - Once sched_idle=1 is sampled with sched_en=0, go to PREA.
- PREA (1 cycle): all cs_n=0, ras/cas/we=0,1,0, a10=1. Load the counter with T_RP-1 and go to PREA_WAIT; on expiry go to REF.
- REF (1 cycle): all cs_n=0, ras/cas/we=0,0,1, a10=0. Load the counter with T_RFC-1 and go to REF_WAIT.
  - On expiry, decrement ref_pending.
  - If the decremented value is >0, go to REF again; no further PREA.
  - Otherwise go to IDLE.
- Refresh timer:
  - Starts at T_REFI-1 on the first entry to IDLE and decrements every cycle in all states after that. It never restarts except at reset.
  - Tick at 0: reload and ref_pending+1.
  - If ref_pending==MAX_POSTPONE at a tick, the count holds and ref_overflow sets (cleared only by reset).
  - Tick coinciding with the REF_WAIT decrement: net ref_pending unchanged; the sequencer stays in the REF loop.
- Outside the issue cycles, the command slot is NOP-deselect: cmd_valid=0, cs_n all 1, ras/cas/we=1, a10=0.
- ref_pending width: $clog2(MAX_POSTPONE+1).

## Timing
- All outputs are registered; the decision is made on state/next and the output changes on the edge that enters the state.
- Reset values: dfi_init_start=0, ddr_init_start=0, sched_en=0, ref_urgent=0, ref_overflow=0, cmd_valid=0, cmd_cs_n all 1, ras/cas/we=1, a10=0.
- Internal reset values: state=RESET, timers 0, ref_pending=0.
- Command spacing:
  - ZQCL to the next ZQCL: exactly T_ZQINIT cycles.
  - PREA to REF: exactly T_RP cycles.
  - REF to REF: exactly T_RFC cycles.
- sched_en falls on the edge after the tick that makes ref_pending nonzero. The scheduler sees sched_en=0 at least one cycle before PREA.
- sched_en rises on the edge leaving REF_WAIT into IDLE.
- Asynchronous reset mid-sequence (including during REF_WAIT) forces all outputs to reset values immediately; the sequence restarts from RESET.
- Inputs are sampled only in their owning state. dfi_init_complete or ddr_init_done held high elsewhere is ignored.

## Test plan
- Init sequence, NUM_RANKS=2, T_ZQINIT=16:
  - dfi_init_complete at cycle 10 -> dfi_init_start high from cycle 1 to 10.
  - ddr_init_done 5 cycles later -> ddr_init_start high until then.
  - Two ZQCL pulses with cs_n=10 then 01, 16 cycles apart.
  - sched_en=1 on the edge after the second ZQWAIT expires.
- Single refresh, T_REFI=100, T_RP=6, T_RFC=20, sched_idle tied 1:
  - sched_en drops 100 cycles after IDLE entry.
  - PREA with a10=1 on all ranks, REF 6 cycles later, sched_en back 20 cycles after REF.
- Postponement: hold sched_idle=0 for 3.5*T_REFI, then release -> ref_pending=3, one PREA, then three REFs spaced T_RFC, then IDLE.
- Saturation, MAX_POSTPONE=2: hold sched_idle=0 for 3*T_REFI -> ref_urgent=1 after the 2nd tick, ref_overflow=1 after the 3rd tick, ref_pending stays 2.
- Collision: align a timer tick with the REF_WAIT expiry (pending=1) -> second REF issued, no return to IDLE between.
- Reset mid-REF_WAIT: deassert core_arstn -> all outputs at reset values that cycle; the full init sequence repeats after release.

Source files
------------

// File: rtl/ddr_main_sequencer.sv
//------------------------------------------------------------------------------
// Module      : ddr_main_sequencer
// Description : Top-level DDR3 sequencer. Brings the PHY and DRAM out of
//               reset, runs per-rank ZQ long calibration, then hands the
//               command bus to the scheduler. It reclaims the bus
//               periodically for PREA + REF, with postponed-refresh
//               accounting.
// Ports       : core_clk, core_arstn (async, active-low)
//               dfi_init_start / dfi_init_complete  - PHY init handshake
//               ddr_init_start / ddr_init_done      - DRAM init engine handshake
//               sched_en / sched_idle               - scheduler bus ownership
//               ref_urgent, ref_overflow            - refresh backlog status
//               cmd_valid, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10
//                                                   - registered command slot
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr_main_sequencer #(
  parameter int NUM_RANKS    = 1,
  parameter int CNT_W        = 16,
  parameter int T_ZQINIT     = 512,
  parameter int T_RP         = 6,
  parameter int T_RFC        = 88,
  parameter int T_REFI       = 6240,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                 core_clk,
  input  logic                 core_arstn,
  output logic                 dfi_init_start,
  input  logic                 dfi_init_complete,
  output logic                 ddr_init_start,
  input  logic                 ddr_init_done,
  output logic                 sched_en,
  input  logic                 sched_idle,
  output logic                 ref_urgent,
  output logic                 ref_overflow,
  output logic                 cmd_valid,
  output logic [NUM_RANKS-1:0] cmd_cs_n,
  output logic                 cmd_ras_n,
  output logic                 cmd_cas_n,
  output logic                 cmd_we_n,
  output logic                 cmd_a10
);

  localparam int c_pend_w = $clog2(MAX_POSTPONE + 1);
  localparam int c_rank_w = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;

  localparam logic [CNT_W-1:0]    c_zq_load   = CNT_W'(T_ZQINIT - 1);
  localparam logic [CNT_W-1:0]    c_rp_load   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0]    c_rfc_load  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0]    c_refi_load = CNT_W'(T_REFI - 1);
  localparam logic [c_pend_w-1:0] c_max_pend  = c_pend_w'(MAX_POSTPONE);
  localparam logic [c_rank_w-1:0] c_last_rank = c_rank_w'(NUM_RANKS - 1);

  localparam logic [3:0] c_st_reset     = 4'd0;
  localparam logic [3:0] c_st_init_dfi  = 4'd1;
  localparam logic [3:0] c_st_init_ddr  = 4'd2;
  localparam logic [3:0] c_st_zqcal     = 4'd3;
  localparam logic [3:0] c_st_zqwait    = 4'd4;
  localparam logic [3:0] c_st_idle      = 4'd5;
  localparam logic [3:0] c_st_prea      = 4'd6;
  localparam logic [3:0] c_st_prea_wait = 4'd7;
  localparam logic [3:0] c_st_ref       = 4'd8;
  localparam logic [3:0] c_st_ref_wait  = 4'd9;

  logic [3:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [c_rank_w-1:0] r_rank;
  logic [c_pend_w-1:0] r_pend;
  logic [CNT_W-1:0]    r_refi_cnt;
  logic                r_refi_run;

  logic [3:0]          w_state_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [c_rank_w-1:0] w_rank_next;
  logic [c_pend_w-1:0] w_pend_next;
  logic                w_tick;
  logic                w_sat;
  logic                w_dec;

  logic                 w_dfi_init_start;
  logic                 w_ddr_init_start;
  logic                 w_sched_en;
  logic                 w_ref_urgent;
  logic                 w_cmd_valid;
  logic [NUM_RANKS-1:0] w_cmd_cs_n;
  logic                 w_cmd_ras_n;
  logic                 w_cmd_cas_n;
  logic                 w_cmd_we_n;
  logic                 w_cmd_a10;

  // Refresh interval timer: free-running once IDLE is first reached.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      r_refi_cnt <= '0;
      r_refi_run <= 1'b0;
    end else if (!r_refi_run) begin
      if (w_state_next == c_st_idle) begin
        r_refi_run <= 1'b1;
        r_refi_cnt <= c_refi_load;
      end
    end else if (r_refi_cnt == '0) begin
      r_refi_cnt <= c_refi_load;
    end else begin
      r_refi_cnt <= r_refi_cnt - 1'b1;
    end
  end

  assign w_tick = r_refi_run && (r_refi_cnt == '0);
  assign w_sat  = (r_pend == c_max_pend);
  // A refresh completes when the REF timing window expires.
  assign w_dec  = ((r_state == c_st_ref) || (r_state == c_st_ref_wait)) &&
                  (r_cnt == '0) && (r_pend != '0);

  // Pending-refresh accounting; a tick and a completion in the same cycle
  // cancel out. A tick while saturated is dropped.
  always_comb begin
    w_pend_next = r_pend;
    case ({w_tick && !w_sat, w_dec})
      2'b10:   w_pend_next = r_pend + 1'b1;
      2'b01:   w_pend_next = r_pend - 1'b1;
      default: w_pend_next = r_pend;
    endcase
  end

  // Next-state logic. Issue states load the counter on entry so the
  // command-to-command spacing equals the timing parameter exactly; the
  // issue cycle and its wait state therefore share one expiry check.
  always_comb begin
    w_state_next = r_state;
    w_rank_next  = r_rank;
    case (r_state)
      c_st_reset:    w_state_next = c_st_init_dfi;
      c_st_init_dfi: if (dfi_init_complete) w_state_next = c_st_init_ddr;
      c_st_init_ddr: begin
        if (ddr_init_done) begin
          w_state_next = c_st_zqcal;
          w_rank_next  = '0;
        end
      end
      c_st_zqcal, c_st_zqwait: begin
        if (r_cnt == '0) begin
          if (r_rank == c_last_rank) begin
            w_state_next = c_st_idle;
          end else begin
            w_state_next = c_st_zqcal;
            w_rank_next  = r_rank + 1'b1;
          end
        end else begin
          w_state_next = c_st_zqwait;
        end
      end
      c_st_idle: begin
        // The scheduler must have seen sched_en low before it reports idle.
        if (!sched_en && sched_idle && (r_pend != '0)) w_state_next = c_st_prea;
      end
      c_st_prea, c_st_prea_wait: begin
        w_state_next = (r_cnt == '0) ? c_st_ref : c_st_prea_wait;
      end
      c_st_ref, c_st_ref_wait: begin
        if (r_cnt == '0) begin
          w_state_next = (w_pend_next != '0) ? c_st_ref : c_st_idle;
        end else begin
          w_state_next = c_st_ref_wait;
        end
      end
      default: w_state_next = c_st_reset;
    endcase
  end

  always_comb begin
    case (w_state_next)
      c_st_zqcal: w_cnt_next = c_zq_load;
      c_st_prea:  w_cnt_next = c_rp_load;
      c_st_ref:   w_cnt_next = c_rfc_load;
      default:    w_cnt_next = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    endcase
  end

  // Output values for the state being entered; registered below.
  always_comb begin
    w_dfi_init_start = (w_state_next == c_st_init_dfi);
    w_ddr_init_start = (w_state_next == c_st_init_ddr);
    w_sched_en       = (w_state_next == c_st_idle) && (w_pend_next == '0);
    w_ref_urgent     = (w_pend_next == c_max_pend);
    w_cmd_valid      = 1'b0;
    w_cmd_cs_n       = '1;
    w_cmd_ras_n      = 1'b1;
    w_cmd_cas_n      = 1'b1;
    w_cmd_we_n       = 1'b1;
    w_cmd_a10        = 1'b0;
    case (w_state_next)
      c_st_zqcal: begin
        w_cmd_valid = 1'b1;
        for (int i = 0; i < NUM_RANKS; i++) begin
          w_cmd_cs_n[i] = (w_rank_next != c_rank_w'(i));
        end
        w_cmd_we_n = 1'b0;
        w_cmd_a10  = 1'b1;
      end
      c_st_prea: begin
        w_cmd_valid = 1'b1;
        w_cmd_cs_n  = '0;
        w_cmd_ras_n = 1'b0;
        w_cmd_we_n  = 1'b0;
        w_cmd_a10   = 1'b1;
      end
      c_st_ref: begin
        w_cmd_valid = 1'b1;
        w_cmd_cs_n  = '0;
        w_cmd_ras_n = 1'b0;
        w_cmd_cas_n = 1'b0;
      end
      default: begin
        w_cmd_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      r_state        <= c_st_reset;
      r_cnt          <= '0;
      r_rank         <= '0;
      r_pend         <= '0;
      dfi_init_start <= 1'b0;
      ddr_init_start <= 1'b0;
      sched_en       <= 1'b0;
      ref_urgent     <= 1'b0;
      ref_overflow   <= 1'b0;
      cmd_valid      <= 1'b0;
      cmd_cs_n       <= '1;
      cmd_ras_n      <= 1'b1;
      cmd_cas_n      <= 1'b1;
      cmd_we_n       <= 1'b1;
      cmd_a10        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_rank         <= w_rank_next;
      r_pend         <= w_pend_next;
      dfi_init_start <= w_dfi_init_start;
      ddr_init_start <= w_ddr_init_start;
      sched_en       <= w_sched_en;
      ref_urgent     <= w_ref_urgent;
      if (w_tick && w_sat) ref_overflow <= 1'b1;
      cmd_valid      <= w_cmd_valid;
      cmd_cs_n       <= w_cmd_cs_n;
      cmd_ras_n      <= w_cmd_ras_n;
      cmd_cas_n      <= w_cmd_cas_n;
      cmd_we_n       <= w_cmd_we_n;
      cmd_a10        <= w_cmd_a10;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddr_main_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_ddr_main_sequencer
// Description : Self-checking bench for ddr_main_sequencer (2 ranks,
//               T_ZQINIT=16, T_RP=6, T_RFC=20, T_REFI=100, MAX_POSTPONE=3).
//               Checkpoint table drives inputs and checks status outputs;
//               expected command / sched_en edge events go to a scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr_main_sequencer;

  localparam logic [2:0] K_ZQ   = 3'd1;
  localparam logic [2:0] K_PREA = 3'd2;
  localparam logic [2:0] K_REF  = 3'd3;
  localparam logic [2:0] K_RISE = 3'd4;
  localparam logic [2:0] K_FALL = 3'd5;
  localparam logic [2:0] K_BAD  = 3'd7;
  localparam int N_ROWS = 21;
  localparam int N_EVS  = 21;

  typedef struct {
    int         cyc;
    logic [2:0] drv;   // {sched_idle, dfi_init_complete, ddr_init_done}
    logic [4:0] exp;   // {dfi_init_start, ddr_init_start, sched_en, ref_urgent, ref_overflow}
  } chk_t;

  typedef struct {
    int         trig;
    logic [2:0] kind;
    logic [1:0] cs;
    int         cyc;
  } ev_t;

  logic       core_clk = 1'b0;
  logic       core_arstn = 1'b0;
  logic       dfi_init_complete = 1'b0;
  logic       ddr_init_done = 1'b0;
  logic       sched_idle = 1'b1;
  logic       dfi_init_start, ddr_init_start, sched_en, ref_urgent, ref_overflow;
  logic       cmd_valid, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10;
  logic [1:0] cmd_cs_n;

  int   cyc;
  int   n_chk = 0;
  int   n_fail = 0;
  chk_t rows[N_ROWS];
  ev_t  evs[N_EVS];
  ev_t  sb[$];

  ddr_main_sequencer #(
    .NUM_RANKS(2), .CNT_W(16), .T_ZQINIT(16), .T_RP(6), .T_RFC(20),
    .T_REFI(100), .MAX_POSTPONE(3)
  ) dut (
    .core_clk(core_clk), .core_arstn(core_arstn),
    .dfi_init_start(dfi_init_start), .dfi_init_complete(dfi_init_complete),
    .ddr_init_start(ddr_init_start), .ddr_init_done(ddr_init_done),
    .sched_en(sched_en), .sched_idle(sched_idle),
    .ref_urgent(ref_urgent), .ref_overflow(ref_overflow),
    .cmd_valid(cmd_valid), .cmd_cs_n(cmd_cs_n), .cmd_ras_n(cmd_ras_n),
    .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n), .cmd_a10(cmd_a10)
  );

  always #5 core_clk = ~core_clk;

  // Cycle index since reset release: after edge k, cyc == k.
  always @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) cyc <= 0;
    else             cyc <= cyc + 1;
  end

  function automatic chk_t mk_row(int c, logic [2:0] d, logic [4:0] e);
    chk_t r;
    r.cyc = c; r.drv = d; r.exp = e;
    return r;
  endfunction

  function automatic ev_t mk_ev(int t, logic [2:0] k, logic [1:0] cs, int c);
    ev_t e;
    e.trig = t; e.kind = k; e.cs = cs; e.cyc = c;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      while (cyc < rows[i].cyc) @(negedge core_clk);
      check($sformatf("dfi_init_start@%0d", cyc), 32'(dfi_init_start), 32'(rows[i].exp[4]));
      check($sformatf("ddr_init_start@%0d", cyc), 32'(ddr_init_start), 32'(rows[i].exp[3]));
      check($sformatf("sched_en@%0d", cyc),       32'(sched_en),       32'(rows[i].exp[2]));
      check($sformatf("ref_urgent@%0d", cyc),     32'(ref_urgent),     32'(rows[i].exp[1]));
      check($sformatf("ref_overflow@%0d", cyc),   32'(ref_overflow),   32'(rows[i].exp[0]));
      sched_idle        = rows[i].drv[2];
      dfi_init_complete = rows[i].drv[1];
      ddr_init_done     = rows[i].drv[0];
      for (int k = 0; k < N_EVS; k++) begin
        if (evs[k].trig == i) sb.push_back(evs[k]);
      end
    end
  endtask

  // Monitor: every command issue and sched_en edge must match the
  // scoreboard head; idle slots must be NOP-deselect.
  initial begin : monitor
    logic       prev_en;
    logic [2:0] kind;
    ev_t        e;
    prev_en = 1'b0;
    forever begin
      @(negedge core_clk);
      if (!core_arstn) begin
        prev_en = 1'b0;
      end else begin
        if (cmd_valid) begin
          case ({cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10})
            4'b1101: kind = K_ZQ;
            4'b0101: kind = K_PREA;
            4'b0010: kind = K_REF;
            default: kind = K_BAD;
          endcase
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_cmd: got kind=%0d cs=%b at cyc=%0d expected none", kind, cmd_cs_n, cyc);
          end else begin
            e = sb.pop_front();
            if (e.kind !== kind || e.cs !== cmd_cs_n || e.cyc != cyc) begin
              n_fail++;
              $display("FAIL cmd_event: got kind=%0d cs=%b cyc=%0d expected kind=%0d cs=%b cyc=%0d",
                       kind, cmd_cs_n, cyc, e.kind, e.cs, e.cyc);
            end
          end
        end else begin
          check($sformatf("nop_slot@%0d", cyc),
                32'({cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10}), 32'(6'b111110));
        end
        if (sched_en !== prev_en) begin
          kind = sched_en ? K_RISE : K_FALL;
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_sched_en_edge: got kind=%0d at cyc=%0d expected none", kind, cyc);
          end else begin
            e = sb.pop_front();
            if (e.kind !== kind || e.cyc != cyc) begin
              n_fail++;
              $display("FAIL sched_en_event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                       kind, cyc, e.kind, e.cyc);
            end
          end
        end
        prev_en = sched_en;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    //                      cyc  {idle,dfi,ddr} {dfi_s,ddr_s,en,urg,ovf}
    rows[0]  = mk_row(1,   3'b100, 5'b10000);
    rows[1]  = mk_row(10,  3'b110, 5'b10000);  // PHY init completes
    rows[2]  = mk_row(11,  3'b110, 5'b01000);
    rows[3]  = mk_row(15,  3'b111, 5'b01000);  // DRAM init done
    rows[4]  = mk_row(16,  3'b111, 5'b00000);
    rows[5]  = mk_row(48,  3'b111, 5'b00100);  // IDLE entered, timer starts
    rows[6]  = mk_row(147, 3'b111, 5'b00100);
    rows[7]  = mk_row(148, 3'b111, 5'b00000);  // first tick
    rows[8]  = mk_row(180, 3'b011, 5'b00100);  // scheduler goes busy
    rows[9]  = mk_row(300, 3'b011, 5'b00000);
    rows[10] = mk_row(447, 3'b011, 5'b00000);
    rows[11] = mk_row(448, 3'b011, 5'b00010);  // pending saturates at 3
    rows[12] = mk_row(547, 3'b011, 5'b00010);
    rows[13] = mk_row(560, 3'b111, 5'b00011);  // overflow after 4th tick; release
    rows[14] = mk_row(586, 3'b111, 5'b00011);
    rows[15] = mk_row(587, 3'b111, 5'b00001);  // first REF done, pending 2
    rows[16] = mk_row(630, 3'b011, 5'b00101);
    rows[17] = mk_row(721, 3'b111, 5'b00001);  // release so REF_WAIT ends on a tick
    rows[18] = mk_row(767, 3'b111, 5'b00001);
    rows[19] = mk_row(768, 3'b111, 5'b00101);
    rows[20] = mk_row(860, 3'b111, 5'b00001);  // inside REF_WAIT

    evs[0]  = mk_ev(3,  K_ZQ,   2'b10, 16);
    evs[1]  = mk_ev(3,  K_ZQ,   2'b01, 32);
    evs[2]  = mk_ev(3,  K_RISE, 2'b11, 48);
    evs[3]  = mk_ev(5,  K_FALL, 2'b11, 148);
    evs[4]  = mk_ev(5,  K_PREA, 2'b00, 149);
    evs[5]  = mk_ev(5,  K_REF,  2'b00, 155);
    evs[6]  = mk_ev(5,  K_RISE, 2'b11, 175);
    evs[7]  = mk_ev(8,  K_FALL, 2'b11, 248);
    evs[8]  = mk_ev(13, K_PREA, 2'b00, 561);
    evs[9]  = mk_ev(13, K_REF,  2'b00, 567);
    evs[10] = mk_ev(13, K_REF,  2'b00, 587);
    evs[11] = mk_ev(13, K_REF,  2'b00, 607);
    evs[12] = mk_ev(13, K_RISE, 2'b11, 627);
    evs[13] = mk_ev(16, K_FALL, 2'b11, 648);
    evs[14] = mk_ev(17, K_PREA, 2'b00, 722);
    evs[15] = mk_ev(17, K_REF,  2'b00, 728);
    evs[16] = mk_ev(17, K_REF,  2'b00, 748);  // tick collides with expiry
    evs[17] = mk_ev(17, K_RISE, 2'b11, 768);
    evs[18] = mk_ev(17, K_FALL, 2'b11, 848);
    evs[19] = mk_ev(17, K_PREA, 2'b00, 849);
    evs[20] = mk_ev(17, K_REF,  2'b00, 855);

    // Reset state
    repeat (2) @(negedge core_clk);
    check("rst_dfi_init_start", 32'(dfi_init_start), 32'd0);
    check("rst_sched_en",       32'(sched_en),       32'd0);
    check("rst_cmd_slot", 32'({cmd_valid, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10}),
          32'(7'b0111110));
    core_arstn = 1'b1;

    run_rows(0, N_ROWS - 1);
    check("sb_drained_before_reset", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of REF_WAIT
    #2 core_arstn = 1'b0;
    #1;
    check("arst_dfi_init_start", 32'(dfi_init_start), 32'd0);
    check("arst_ddr_init_start", 32'(ddr_init_start), 32'd0);
    check("arst_sched_en",       32'(sched_en),       32'd0);
    check("arst_ref_urgent",     32'(ref_urgent),     32'd0);
    check("arst_ref_overflow",   32'(ref_overflow),   32'd0);
    check("arst_cmd_slot", 32'({cmd_valid, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10}),
          32'(7'b0111110));
    dfi_init_complete = 1'b0;
    ddr_init_done     = 1'b0;
    sched_idle        = 1'b1;
    repeat (3) @(negedge core_clk);
    core_arstn = 1'b1;

    // Full init plus first refresh must repeat from scratch
    run_rows(0, 7);
    while (cyc < 180) @(negedge core_clk);
    check("sb_drained_after_reinit", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
